plic_multi_ctx: RTL and testbench
=================================

PLIC_MULTI_CTX -- requirements
Module: plic_multi_ctx

Interface
REQ-001 SHALL have parameter NUM_SRC, default 32, meaning source count including reserved ID 0, legal range 2..64.
REQ-002 SHALL have parameter NUM_CTX, default 2, meaning context count, legal range 1..8; ctx 2h = hart h M-mode, ctx 2h+1 = hart h S-mode.
REQ-003 SHALL have parameter PRIO_W, default 3, meaning implemented priority/threshold bits.
REQ-004 SHALL have ports, clock first:
 clock  in  1  sole clock; one clock, everything on its rising edge
 reset_n  in  1  asynchronous, active-low reset
 req_in  in  device_req_t  MMIO ld/st from LSU; at most one per cycle
 res_out  out  device_res_t  read response
 irq_src  in  NUM_SRC  device interrupt lines; bit 0 ignored
 eip  out  NUM_CTX  external-interrupt-pending per context, to CSR mip.MEIP/SEIP

Function
REQ-005 SHALL decode 32-bit accesses relative to base 0x0C00_0000:
 - priority[i] at 4*i.
 - pending word w at 0x1000+4w (read-only).
 - enable ctx c, word w at 0x2000+0x80c+4w.
 - threshold ctx c at 0x20_0000+0x1000c.
 - claim/complete ctx c at 0x20_0004+0x1000c.
REQ-006 SHALL answer every read with res_out.valid=1, id=req_in.id exactly 1 cycle after req_in.valid; data zero-extended to 64 bits.
REQ-007 SHALL return data 0 for reads of unmapped offsets or sources >= NUM_SRC; writes there SHALL be ignored.
REQ-008 SHALL NOT produce a response for writes.
REQ-009 SHALL keep only low PRIO_W bits of priority/threshold writes; upper bits read 0.
REQ-010 SHALL hardwire priority[0], pending[0] and enable bit 0 to 0.
REQ-011 Level gateway: pending[i] SHALL set in the cycle irq_src[i]=1 and in_service[i]=0.
REQ-012 SHALL keep pending[i] set until claimed; deassertion of irq_src[i] SHALL NOT clear it.
REQ-013 Source i SHALL be eligible for ctx c iff pending[i] & !in_service[i] & enable[c][i] & priority[i] > threshold[c].
REQ-014 SHALL select highest priority among eligible sources; ties SHALL go to the lowest ID.
REQ-015 Claim read SHALL evaluate eligibility on same-cycle post-gateway state.
REQ-016 Claim read SHALL return the winning ID, clear its pending and set its in_service next edge.
REQ-017 Claim read SHALL return 0 with no state change when nothing is eligible.
REQ-018 Complete write SHALL clear in_service[data[5:0]] next edge.
REQ-019 Complete write SHALL be ignored if ID is 0, ID >= NUM_SRC, or not enabled for that ctx.
REQ-020 A source whose line is still high at complete SHALL re-pend the cycle after in_service clears.
REQ-021 eip[c] SHALL be registered: high one cycle after any source becomes eligible for c; low one cycle after none is.

Reset
REQ-022 reset_n low SHALL asynchronously clear all priority, pending, in_service, enable, threshold, edge state, res_out and eip to 0.
REQ-023 A request in flight at reset SHALL be dropped; no response after reset release.

Configuration
REQ-024 With PLIC_EDGE_TRIG_EN defined:
 - read/write trigger-type word w at 0x1F00+4w; bit=1 selects edge.
 - edge source sets pending on a rising edge of irq_src vs. its registered previous value.
 - edge occurring while in_service SHALL latch into a one-deep edge_hold flag and pend the cycle after complete.
REQ-025 Without PLIC_EDGE_TRIG_EN: 0x1F00 region reads 0 and ignores writes; all sources level-triggered; no edge state instantiated.

Verification
REQ-026 prio[10]=1, enable ctx1 bit10, thr1=0, irq_src[10]=1 -> eip[1]=1; claim ctx1 reads 10; eip[1]=0 next cycle.
REQ-027 Sources 3 and 5 both prio 2, enabled ctx0 -> claim returns 3, then 5, then 0.
REQ-028 prio[7]=2, thr0=2 -> eip[0] stays 0; thr0=1 -> eip[0]=1 one cycle later.
REQ-029 Claim 10 with irq_src[10] held high; complete 10 -> pending[10] reads 1, claim returns 10 again; complete ID 40 with NUM_SRC=32 -> no state change.
REQ-030 PLIC_EDGE_TRIG_EN, source 4 edge, two pulses during service -> after complete, one re-pend only; claim returns 4 once, then 0.

Source files
------------

// File: rtl/plic_multi_ctx.sv
// +----------------------------------------------------------------------+
// | Module   : plic_multi_ctx                                            |
// | Desc     : Multi-context platform-level interrupt controller with    |
// |            level gateways, per-context enable/threshold, priority    |
// |            arbitration and claim/complete over a 32-bit MMIO window  |
// |            at 0x0C00_0000.                                           |
// | Options  : PLIC_EDGE_TRIG_EN - per-source edge-triggered gateways    |
// |            (trigger-type words at 0x1F00, one-deep edge hold).       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package plic_multi_ctx_pkg;
  typedef struct packed {
    logic        valid;
    logic        we;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [63:0] wdata;
  } device_req_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  id;
    logic [63:0] data;
  } device_res_t;
endpackage

module plic_multi_ctx
  import plic_multi_ctx_pkg::*;
#(
  parameter int NUM_SRC = 32,
  parameter int NUM_CTX = 2,
  parameter int PRIO_W  = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  device_req_t        req_in,
  output device_res_t        res_out,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic [NUM_CTX-1:0] eip
);

  // Window tag: addr[31:26] of 0x0C00_0000..0x0FFF_FFFF
  localparam logic [5:0]         c_win_tag  = 6'h03;
  // Source 0 is reserved; it never pends, never arbitrates
  localparam logic [NUM_SRC-1:0] c_src_mask = {{(NUM_SRC-1){1'b1}}, 1'b0};

  // Architectural state
  logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q, prio_d;
  logic [NUM_SRC-1:0]             pending_q, pending_d;
  logic [NUM_SRC-1:0]             in_service_q, in_service_d;
  logic [NUM_CTX-1:0][NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_CTX-1:0][PRIO_W-1:0] thr_q, thr_d;
  logic [NUM_CTX-1:0]             eip_q, eip_d;
  device_res_t                    res_q, res_d;

  // Gateway and arbitration results
  logic [NUM_SRC-1:0]             gate_set;
  logic [NUM_SRC-1:0]             pend_eff;
  logic [NUM_CTX-1:0][5:0]        best_id;
  logic [NUM_CTX-1:0][PRIO_W-1:0] best_prio;
  logic [31:0]                    rd_data;

  // Address decode
  logic [25:0] off;
  logic        in_win;
  logic        sel_prio, sel_pend, sel_trig, sel_en, sel_ctx, sel_thr, sel_claim;
  logic [9:0]  src_idx;
  logic [4:0]  word_idx;
  logic [13:0] en_ctx;
  logic [13:0] ctx_idx;

  assign off       = req_in.addr[25:0];
  assign in_win    = (req_in.addr[31:26] == c_win_tag);
  assign src_idx   = off[11:2];
  assign word_idx  = off[6:2];
  assign en_ctx    = off[20:7] - 14'h0040;
  assign ctx_idx   = off[25:12] - 14'h0200;
  assign sel_prio  = in_win && (off[25:12] == 14'h0000);
  assign sel_pend  = in_win && (off[25:7] == 19'h00020);
  assign sel_trig  = in_win && (off[25:7] == 19'h0003E);
  assign sel_en    = in_win && (off[25:21] == 5'd0) && (off[20:13] != 8'd0);
  assign sel_ctx   = in_win && (off[25:21] != 5'd0);
  assign sel_thr   = sel_ctx && (off[11:0] == 12'h000);
  assign sel_claim = sel_ctx && (off[11:0] == 12'h004);

  logic unused_wdata;
  assign unused_wdata = ^req_in.wdata[63:32];

`ifdef PLIC_EDGE_TRIG_EN
  logic [NUM_SRC-1:0] trig_q, trig_d;
  logic [NUM_SRC-1:0] irq_prev_q;
  logic [NUM_SRC-1:0] edge_hold_q, edge_hold_d;
  logic [NUM_SRC-1:0] rise;
  logic               unused_edge;

  assign rise        = irq_src & ~irq_prev_q;
  assign unused_edge = ^{rise[0], trig_q[0], edge_hold_q[0]};

  // Gateway: level sources follow the line, edge sources pend on a fresh or held edge
  always_comb begin
    gate_set    = '0;
    edge_hold_d = '0;
    for (int s = 1; s < NUM_SRC; s++) begin
      if (trig_q[s]) begin
        gate_set[s]    = ~in_service_q[s] & (rise[s] | edge_hold_q[s]);
        edge_hold_d[s] =  in_service_q[s] & (rise[s] | edge_hold_q[s]);
      end else begin
        gate_set[s] = irq_src[s] & ~in_service_q[s];
      end
    end
  end

  // Edge-gateway state: trigger types, previous line level, held edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      trig_q      <= '0;
      irq_prev_q  <= '0;
      edge_hold_q <= '0;
    end else begin
      trig_q      <= trig_d;
      irq_prev_q  <= irq_src;
      edge_hold_q <= edge_hold_d;
    end
  end
`else
  // Gateway: every source is level-triggered and blocked while in service
  assign gate_set = irq_src & ~in_service_q & c_src_mask;
`endif

  assign pend_eff = pending_q | gate_set;

  // Per-context arbitration on post-gateway state; strict compare keeps ties at lowest ID
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int c = 0; c < NUM_CTX; c++) begin
      for (int s = 1; s < NUM_SRC; s++) begin
        if (pend_eff[s] && !in_service_q[s] && enable_q[c][s] &&
            (prio_q[s] > thr_q[c]) && (prio_q[s] > best_prio[c])) begin
          best_prio[c] = prio_q[s];
          best_id[c]   = 6'(s);
        end
      end
    end
  end

  // Register file access, claim and complete
  always_comb begin
    prio_d       = prio_q;
    enable_d     = enable_q;
    thr_d        = thr_q;
    pending_d    = pend_eff;
    in_service_d = in_service_q;
`ifdef PLIC_EDGE_TRIG_EN
    trig_d       = trig_q;
`endif
    rd_data      = '0;
    if (req_in.valid && req_in.we) begin
      if (sel_prio)
        for (int s = 1; s < NUM_SRC; s++)
          if (int'(src_idx) == s) prio_d[s] = req_in.wdata[PRIO_W-1:0];
`ifdef PLIC_EDGE_TRIG_EN
      if (sel_trig)
        for (int s = 1; s < NUM_SRC; s++)
          if (int'(word_idx) == s / 32) trig_d[s] = req_in.wdata[s % 32];
`endif
      if (sel_en)
        for (int c = 0; c < NUM_CTX; c++)
          for (int s = 1; s < NUM_SRC; s++)
            if ((int'(en_ctx) == c) && (int'(word_idx) == s / 32))
              enable_d[c][s] = req_in.wdata[s % 32];
      if (sel_thr)
        for (int c = 0; c < NUM_CTX; c++)
          if (int'(ctx_idx) == c) thr_d[c] = req_in.wdata[PRIO_W-1:0];
      if (sel_claim)
        for (int c = 0; c < NUM_CTX; c++)
          for (int s = 1; s < NUM_SRC; s++)
            if ((int'(ctx_idx) == c) && (int'(req_in.wdata[5:0]) == s) && enable_q[c][s])
              in_service_d[s] = 1'b0;
    end else if (req_in.valid) begin
      if (sel_prio)
        for (int s = 0; s < NUM_SRC; s++)
          if (int'(src_idx) == s) rd_data[PRIO_W-1:0] = prio_q[s];
      if (sel_pend)
        for (int s = 0; s < NUM_SRC; s++)
          if (int'(word_idx) == s / 32) rd_data[s % 32] = pend_eff[s];
`ifdef PLIC_EDGE_TRIG_EN
      if (sel_trig)
        for (int s = 0; s < NUM_SRC; s++)
          if (int'(word_idx) == s / 32) rd_data[s % 32] = trig_q[s];
`endif
      if (sel_en)
        for (int c = 0; c < NUM_CTX; c++)
          for (int s = 0; s < NUM_SRC; s++)
            if ((int'(en_ctx) == c) && (int'(word_idx) == s / 32))
              rd_data[s % 32] = enable_q[c][s];
      if (sel_thr)
        for (int c = 0; c < NUM_CTX; c++)
          if (int'(ctx_idx) == c) rd_data[PRIO_W-1:0] = thr_q[c];
      if (sel_claim)
        for (int c = 0; c < NUM_CTX; c++)
          if (int'(ctx_idx) == c) begin
            rd_data[5:0] = best_id[c];
            for (int s = 1; s < NUM_SRC; s++)
              if (int'(best_id[c]) == s) begin
                pending_d[s]    = 1'b0;
                in_service_d[s] = 1'b1;
              end
          end
    end
    prio_d[0]       = '0;
    pending_d[0]    = 1'b0;
    in_service_d[0] = 1'b0;
    for (int c = 0; c < NUM_CTX; c++) enable_d[c][0] = 1'b0;
`ifdef PLIC_EDGE_TRIG_EN
    trig_d[0]       = 1'b0;
`endif
  end

  // Read response: one cycle after the request, nothing for writes
  always_comb begin
    res_d = '0;
    if (req_in.valid && !req_in.we) begin
      res_d.valid = 1'b1;
      res_d.id    = req_in.id;
      res_d.data  = {32'b0, rd_data};
    end
  end

  // Interrupt lines track eligibility of the state being registered this edge
  always_comb begin
    eip_d = '0;
    for (int c = 0; c < NUM_CTX; c++)
      for (int s = 1; s < NUM_SRC; s++)
        if (pending_d[s] && !in_service_d[s] && enable_d[c][s] && (prio_d[s] > thr_d[c]))
          eip_d[c] = 1'b1;
  end

  // Core state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_q       <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      enable_q     <= '0;
      thr_q        <= '0;
      eip_q        <= '0;
      res_q        <= '0;
    end else begin
      prio_q       <= prio_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      enable_q     <= enable_d;
      thr_q        <= thr_d;
      eip_q        <= eip_d;
      res_q        <= res_d;
    end
  end

  assign res_out = res_q;
  assign eip     = eip_q;

endmodule

`default_nettype wire

// File: tb/tb_plic_multi_ctx.sv
// +----------------------------------------------------------------------+
// | Module   : tb_plic_multi_ctx                                         |
// | Desc     : Directed self-checking bench for plic_multi_ctx           |
// |            (NUM_SRC=32, NUM_CTX=2, PRIO_W=3). Edge-trigger vectors   |
// |            run when PLIC_EDGE_TRIG_EN is defined.                    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_plic_multi_ctx;
  import plic_multi_ctx_pkg::*;

  localparam int          NSRC = 32;
  localparam int          NCTX = 2;
  localparam int          PW   = 3;
  localparam logic [31:0] BASE = 32'h0C00_0000;

  // Offsets
  localparam logic [31:0] PEND   = 32'h0000_1000;
  localparam logic [31:0] TRIG   = 32'h0000_1F00;
  localparam logic [31:0] EN0    = 32'h0000_2000;
  localparam logic [31:0] EN1    = 32'h0000_2080;
  localparam logic [31:0] THR0   = 32'h0020_0000;
  localparam logic [31:0] CLM0   = 32'h0020_0004;
  localparam logic [31:0] THR1   = 32'h0020_1000;
  localparam logic [31:0] CLM1   = 32'h0020_1004;

  logic             clock;
  logic             reset_n;
  device_req_t      req;
  device_res_t      res;
  logic [NSRC-1:0]  irq;
  logic [NCTX-1:0]  eip;

  int               n_vec;
  int               n_err;
  logic [3:0]       tag_id;

  plic_multi_ctx #(
    .NUM_SRC (NSRC),
    .NUM_CTX (NCTX),
    .PRIO_W  (PW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req_in  (req),
    .res_out (res),
    .irq_src (irq),
    .eip     (eip)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    @(negedge clock);
    req       = '0;
    req.valid = 1'b1;
    req.we    = 1'b1;
    req.addr  = BASE + off;
    req.wdata = {32'b0, data};
    req.id    = tag_id;
    @(posedge clock);
    #1;
    req.valid = 1'b0;
    check("wr_no_rsp", {63'b0, res.valid}, 64'd0);
  endtask

  task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
    @(negedge clock);
    tag_id    = tag_id + 4'd1;
    req       = '0;
    req.valid = 1'b1;
    req.addr  = BASE + off;
    req.id    = tag_id;
    @(posedge clock);
    #1;
    req.valid = 1'b0;
    check({tag, "_vld"}, {63'b0, res.valid}, 64'd1);
    check({tag, "_id"}, {60'b0, res.id}, {60'b0, tag_id});
    check(tag, res.data, {32'b0, exp});
  endtask

  task automatic chk_eip(input string tag, input logic [NCTX-1:0] exp);
    check(tag, {62'b0, eip}, {62'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    tag_id  = 4'd0;
    req     = '0;
    irq     = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_res_vld", {63'b0, res.valid}, 64'd0);
    chk_eip("rst_eip", 2'b00);
    @(negedge clock);
    reset_n = 1'b1;
    idle(1);

    // Register basics: priority width, reserved ID 0, out-of-range and unmapped
    rd("prio10_rst", 32'h28, 32'd0);
    wr(32'h30, 32'hFF);
    rd("prio12_trunc", 32'h30, 32'd7);
    wr(32'h30, 32'h0);
    wr(32'h00, 32'h7);
    rd("prio0_zero", 32'h00, 32'd0);
    wr(32'h80, 32'h5);
    rd("prio32_oor", 32'h80, 32'd0);
    rd("unmapped", 32'h0010_0000, 32'd0);
    rd("thr_ctx2", 32'h0020_2000, 32'd0);
`ifndef PLIC_EDGE_TRIG_EN
    wr(TRIG, 32'hFFFF_FFFF);
    rd("trig_absent", TRIG, 32'd0);
`endif

    // Single source on ctx1, claim, re-pend while line held, ignored completes
    wr(32'h28, 32'd1);
    wr(EN1, 32'h0000_0400);
    rd("en1_rb", EN1, 32'h0000_0400);
    wr(THR1, 32'd0);
    irq[10] = 1'b1;
    idle(2);
    chk_eip("eip_src10", 2'b10);
    rd("pend_src10", PEND, 32'h0000_0400);
    rd("claim1_10", CLM1, 32'd10);
    idle(1);
    chk_eip("eip_after_claim", 2'b00);
    rd("pend_in_svc", PEND, 32'd0);
    wr(CLM1, 32'd10);
    idle(2);
    rd("pend_repend", PEND, 32'h0000_0400);
    chk_eip("eip_repend", 2'b10);
    rd("claim1_10_again", CLM1, 32'd10);
    wr(CLM1, 32'd40);
    wr(CLM0, 32'd10);
    idle(2);
    rd("pend_bad_cmpl", PEND, 32'd0);
    chk_eip("eip_bad_cmpl", 2'b00);
    irq[10] = 1'b0;
    wr(CLM1, 32'd10);
    idle(2);
    rd("pend_idle", PEND, 32'd0);
    rd("claim1_empty", CLM1, 32'd0);

    // Equal priorities on ctx0: lowest ID first, then the other, then none
    wr(EN0, 32'h0000_0029);
    rd("en0_bit0", EN0, 32'h0000_0028);
    wr(32'h0C, 32'd2);
    wr(32'h14, 32'd2);
    wr(THR0, 32'd0);
    irq[3] = 1'b1;
    irq[5] = 1'b1;
    idle(1);
    irq[3] = 1'b0;
    irq[5] = 1'b0;
    idle(2);
    chk_eip("eip_tie", 2'b01);
    rd("pend_latched", PEND, 32'h0000_0028);
    rd("claim0_3", CLM0, 32'd3);
    rd("claim0_5", CLM0, 32'd5);
    rd("claim0_0", CLM0, 32'd0);
    idle(1);
    chk_eip("eip_tie_done", 2'b00);
    wr(CLM0, 32'd3);
    wr(CLM0, 32'd5);

    // Threshold masking
    wr(32'h1C, 32'd2);
    wr(EN0, 32'h0000_0080);
    wr(THR0, 32'd2);
    irq[7] = 1'b1;
    idle(3);
    chk_eip("eip_thr_eq", 2'b00);
    rd("pend_src7", PEND, 32'h0000_0080);
    wr(THR0, 32'd1);
    idle(1);
    chk_eip("eip_thr_lo", 2'b01);
    rd("thr0_rb", THR0, 32'd1);
    wr(THR0, 32'h0000_000A);
    rd("thr0_trunc", THR0, 32'd2);
    idle(1);
    chk_eip("eip_thr_back", 2'b00);
    wr(THR0, 32'd1);
    irq[7] = 1'b0;
    rd("claim0_7", CLM0, 32'd7);
    wr(CLM0, 32'd7);

`ifdef PLIC_EDGE_TRIG_EN
    // Edge source 4: two pulses during service collapse into one re-pend
    wr(TRIG, 32'h0000_0010);
    rd("trig_rb", TRIG, 32'h0000_0010);
    wr(32'h10, 32'd3);
    wr(EN0, 32'h0000_0010);
    wr(THR0, 32'd0);
    irq[4] = 1'b1;
    idle(1);
    irq[4] = 1'b0;
    idle(1);
    rd("edge_claim_4", CLM0, 32'd4);
    irq[4] = 1'b1;
    idle(1);
    irq[4] = 1'b0;
    idle(1);
    irq[4] = 1'b1;
    idle(1);
    irq[4] = 1'b0;
    idle(1);
    rd("edge_pend_svc", PEND, 32'd0);
    wr(CLM0, 32'd4);
    idle(2);
    rd("edge_repend", PEND, 32'h0000_0010);
    rd("edge_claim_4b", CLM0, 32'd4);
    rd("edge_claim_0", CLM0, 32'd0);
    wr(CLM0, 32'd4);
`endif

    // Reset with a read in flight: no response, all state cleared
    irq[10] = 1'b1;
    idle(2);
    chk_eip("eip_pre_rst", 2'b10);
    @(negedge clock);
    req       = '0;
    req.valid = 1'b1;
    req.addr  = BASE + 32'h28;
    req.id    = 4'hA;
    #2;
    reset_n   = 1'b0;
    irq       = '0;
    @(posedge clock);
    #1;
    req.valid = 1'b0;
    check("rst_inflight", {63'b0, res.valid}, 64'd0);
    chk_eip("rst_eip2", 2'b00);
    @(negedge clock);
    reset_n = 1'b1;
    idle(2);
    check("rst_no_late_rsp", {63'b0, res.valid}, 64'd0);
    rd("rst_prio10", 32'h28, 32'd0);
    rd("rst_en1", EN1, 32'd0);
    rd("rst_pend", PEND, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
